gray_ptr_gen: RTL

- Binary-to-Gray direction of the codebase's Gray-code pair.
- Holds a binary up/down counter and publishes its Gray-coded value from a register, so the output is glitch-free and safe to synchronise into another clock domain (e.g. async-FIFO pointers).
- Also flags wrap-around and compares its Gray value against a Gray pointer synchronised in from the far side.

---
 rtl/gray_ptr_gen_pkg.sv | 27 ++
 rtl/gray_ptr_gen_if.sv | 31 +++
 rtl/gray_ptr_gen_enc.sv | 18 +
 rtl/gray_ptr_gen.sv | 90 +++++++++
 4 files changed

// File: rtl/gray_ptr_gen_pkg.sv
// gray_ptr_gen_pkg
// Shared types and helpers for the binary-to-Gray pointer generator.
//   DEFAULT_SIZE : default counter / Gray width
//   step_e       : per-cycle action chosen by the counter
//   bin2gray     : value ^ (value >> 1), evaluated on a 32-bit carrier
//   rst_gray_of  : Gray encoding of a reset value
package gray_ptr_gen_pkg;

  localparam int DEFAULT_SIZE = 8;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2,
    STEP_LOAD = 2'd3
  } step_e;

  // Carrier is 32 bits wide; callers keep the low SIZE bits, so SIZE <= 32.
  function automatic logic [31:0] bin2gray(input logic [31:0] value);
    return value ^ (value >> 1);
  endfunction

  function automatic logic [31:0] rst_gray_of(input logic [31:0] rst_val);
    return bin2gray(rst_val);
  endfunction

endpackage

// File: rtl/gray_ptr_gen_if.sv
// gray_ptr_gen_if
// Control and status bundle of the Gray pointer generator.
//   en, up, load, load_bin, cmp_gray : driven by the controlling side (master)
//   bin, gray, wrap, match           : driven by the generator (slave)
interface gray_ptr_gen_if
  import gray_ptr_gen_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
);

  logic            en;
  logic            up;
  logic            load;
  logic [SIZE-1:0] load_bin;
  logic [SIZE-1:0] cmp_gray;
  logic [SIZE-1:0] bin;
  logic [SIZE-1:0] gray;
  logic            wrap;
  logic            match;

  modport master (
    output en, up, load, load_bin, cmp_gray,
    input  bin, gray, wrap, match
  );

  modport slave (
    input  en, up, load, load_bin, cmp_gray,
    output bin, gray, wrap, match
  );

endinterface

// File: rtl/gray_ptr_gen_enc.sv
// bin2gray_enc
// Combinational binary-to-Gray encoder, one XOR per bit.
//   bin  : binary value in
//   gray : Gray code out (MSB passes straight through)
module bin2gray_enc #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] bin,
  output logic [SIZE-1:0] gray
);

  for (genvar i = 0; i < SIZE - 1; i++) begin : g_bit
    assign gray[i] = bin[i] ^ bin[i+1];
  end

  assign gray[SIZE-1] = bin[SIZE-1];

endmodule

// File: rtl/gray_ptr_gen.sv
// gray_ptr_gen
// Binary up/down counter that publishes its value both in binary and as a
// registered Gray code, suitable for crossing into another clock domain.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (priority over load and en)
//   bus  : gray_ptr_gen_if slave
//          en/up    step the counter by +1/-1
//          load     load load_bin (overrides en)
//          cmp_gray far-side Gray pointer, already synchronised
//          bin/gray registered count and its Gray code
//          wrap     one-cycle pulse when a step crossed all-ones <-> zero
//          match    gray == cmp_gray, registered one cycle later
module gray_ptr_gen
  import gray_ptr_gen_pkg::*;
#(
  parameter int              SIZE    = DEFAULT_SIZE,
  parameter logic [SIZE-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  gray_ptr_gen_if.slave      bus
);

  localparam logic [31:0]     RST_GRAY32 = rst_gray_of(32'(RST_VAL));
  localparam logic [SIZE-1:0] RST_GRAY   = RST_GRAY32[SIZE-1:0];

  step_e           step;
  logic [SIZE-1:0] bin_q;
  logic [SIZE-1:0] gray_q;
  logic            wrap_q;
  logic            match_q;
  logic [SIZE-1:0] bin_n;
  logic [SIZE-1:0] gray_n;
  logic            wrap_n;

  always_comb begin
    step = STEP_HOLD;
    if (bus.load) begin
      step = STEP_LOAD;
    end else if (bus.en) begin
      step = bus.up ? STEP_UP : STEP_DOWN;
    end
  end

  always_comb begin
    bin_n  = bin_q;
    wrap_n = 1'b0;
    case (step)
      STEP_LOAD: bin_n = bus.load_bin;
      STEP_UP: begin
        bin_n  = bin_q + 1'b1;
        wrap_n = &bin_q;
      end
      STEP_DOWN: begin
        bin_n  = bin_q - 1'b1;
        wrap_n = ~|bin_q;
      end
      default: bin_n = bin_q;
    endcase
  end

  // Gray is derived from the next binary value so the gray flop tracks bin
  // in the same cycle and its output never passes through logic.
  bin2gray_enc #(
    .SIZE (SIZE)
  ) u_enc (
    .bin  (bin_n),
    .gray (gray_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= RST_VAL;
      gray_q  <= RST_GRAY;
      wrap_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      bin_q   <= bin_n;
      gray_q  <= gray_n;
      wrap_q  <= wrap_n;
      match_q <= (gray_q == bus.cmp_gray);
    end
  end

  assign bus.bin   = bin_q;
  assign bus.gray  = gray_q;
  assign bus.wrap  = wrap_q;
  assign bus.match = match_q;

endmodule
